fractal_sync_rsp_arbiter: RTL and testbench

Round-robin arbiter that merges the outputs of `N_IN` synchronization-response FIFOs onto one downstream response channel. Each input is a FIFO read port (empty/element/pop), such as the EN and WS ports of a tx datapath or the ports of several sibling tx blocks. The output is a registered valid/ready channel. The block also tracks the index of the source for each forwarded response and detects inputs that wait too long.

---
 rtl/fractal_sync_rsp_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fractal_sync_rsp_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_rsp_arbiter.sv
// rtl/fractal_sync_rsp_arbiter.sv - round-robin merge of N_IN sync-response FIFOs onto one registered channel
//
// Purpose:
//   Scans the input FIFO read ports round-robin, starting at ptr_q. Pops the first
//   non-empty one whenever the output register is free, and forwards the element
//   with its source index on a registered valid/ready channel. Per-input wait
//   counters flag inputs that have been waiting MAX_WAIT cycles or more.
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   empty_i   per-input FIFO empty flag
//   rsp_i     per-input FIFO head element (combinational FIFO output)
//   pop_o     per-input pop, one-hot or zero
//   valid_o   rsp_o/src_o hold a valid response
//   ready_i   downstream accepts the response
//   rsp_o     registered response
//   src_o     index of the input that supplied rsp_o
//   starve_o  per-input starvation level flag

module fractal_sync_rsp_arbiter #(
    parameter type              fsync_rsp_t = logic,
    parameter int unsigned      N_IN        = 2,
    parameter int unsigned      MAX_WAIT    = 15,
    localparam int unsigned     IDX_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_IN-1:0]     empty_i,
    input  fsync_rsp_t          rsp_i [N_IN],
    output logic [N_IN-1:0]     pop_o,
    output logic                valid_o,
    input  logic                ready_i,
    output fsync_rsp_t          rsp_o,
    output logic [IDX_W-1:0]    src_o,
    output logic [N_IN-1:0]     starve_o
);

    localparam int unsigned      WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [IDX_W:0]   N_IN_W   = (IDX_W + 1)'(N_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    if (N_IN == 0) begin : g_bad_n_in
        $fatal(1, "fractal_sync_rsp_arbiter: N_IN must be >= 1");
    end
    if (MAX_WAIT == 0) begin : g_bad_max_wait
        $fatal(1, "fractal_sync_rsp_arbiter: MAX_WAIT must be >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              valid_q, valid_d;
    fsync_rsp_t        rsp_q,   rsp_d;
    logic [IDX_W-1:0]  src_q,   src_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [WAIT_W-1:0] wait_q [N_IN];
    logic [WAIT_W-1:0] wait_d [N_IN];

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic             free;
    logic             any_req;
    logic             gnt;
    logic [IDX_W-1:0] sel;

    assign free = ~valid_q | ready_i;

    // Scan ptr_q, ptr_q+1, ... modulo N_IN; the first non-empty input wins.
    // The sum never exceeds 2*N_IN-2, so one conditional subtract wraps it.
    always_comb begin
        logic [IDX_W:0] sum;
        any_req = 1'b0;
        sel     = '0;
        sum     = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (sum >= N_IN_W) begin
                sum = sum - N_IN_W;
            end
            if (!any_req && !empty_i[sum[IDX_W-1:0]]) begin
                any_req = 1'b1;
                sel     = sum[IDX_W-1:0];
            end
        end
    end

    // rst_ni gates the grant so no FIFO is popped while the block is held in
    // reset (valid_q is 0 then, which would otherwise make the register look free).
    assign gnt = any_req & free & rst_ni;

    always_comb begin
        pop_o = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            pop_o[i] = gnt && (sel == IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Output register next state
    // ------------------------------------------------------------------
    // rsp_i is only sampled through the selected, non-empty lane on a grant,
    // so X on idle lanes never reaches the register.
    always_comb begin
        valid_d = valid_q;
        rsp_d   = rsp_q;
        src_d   = src_q;
        if (gnt) begin
            valid_d = 1'b1;
            rsp_d   = rsp_i[sel];
            src_d   = sel;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            rsp_q   <= '0;
            src_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rsp_q   <= rsp_d;
            src_q   <= src_d;
        end
    end

    assign valid_o = valid_q;
    assign rsp_o   = rsp_q;
    assign src_o   = src_q;

    // ------------------------------------------------------------------
    // Round-robin pointer: restarts just after the last granted input
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        if (gnt) begin
            ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
        end
    end

    if (N_IN == 1) begin : g_ptr_single
        // With one input there is nothing to rotate.
        assign ptr_q = '0;
    end else begin : g_ptr_multi
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation tracking
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < int'(N_IN); i++) begin
            wait_d[i] = wait_q[i];
            if (empty_i[i] || pop_o[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_MAX) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_IN); i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    always_comb begin
        starve_o = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            starve_o[i] = (wait_q[i] == WAIT_MAX);
        end
    end

endmodule

// File: tb/tb_fractal_sync_rsp_arbiter.sv
// tb/tb_fractal_sync_rsp_arbiter.sv - scoreboard bench for fractal_sync_rsp_arbiter

module tb_fractal_sync_rsp_arbiter;

    localparam int N   = 3;
    localparam int MW  = 4;

    typedef logic [7:0] rsp_t;
    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
    } exp_t;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   empty_i;
    rsp_t           rsp_i [N];
    logic [N-1:0]   pop_o;
    logic           valid_o;
    logic           ready_i;
    rsp_t           rsp_o;
    logic [1:0]     src_o;
    logic [N-1:0]   starve_o;

    fractal_sync_rsp_arbiter #(
        .fsync_rsp_t (rsp_t),
        .N_IN        (N),
        .MAX_WAIT    (MW)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .empty_i  (empty_i),
        .rsp_i    (rsp_i),
        .pop_o    (pop_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .rsp_o    (rsp_o),
        .src_o    (src_o),
        .starve_o (starve_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Bench-side input FIFOs, scoreboard and reference model state.
    rsp_t q0[$];
    rsp_t q1[$];
    rsp_t q2[$];
    exp_t sb[$];
    logic mvalid;
    int   mptr;
    int   mwait [N];
    rsp_t next_val = 8'h10;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic rsp_t head(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic push_in(input int i);
        case (i)
            0:       q0.push_back(next_val);
            1:       q1.push_back(next_val);
            default: q2.push_back(next_val);
        endcase
        next_val = next_val + 8'h01;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            empty_i[i] = (qsize(i) == 0);
            rsp_i[i]   = empty_i[i] ? 8'hxx : head(i);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mvalid = 1'b0;
        mptr   = 0;
        for (int i = 0; i < N; i++) mwait[i] = 0;
    endtask

    // One clock cycle: check at the falling edge, advance the model, then pop
    // the bench FIFOs just after the rising edge and re-drive the inputs.
    task automatic step();
        logic [N-1:0] epop;
        logic         free;
        logic         any;
        int           sel;
        exp_t         e;
        @(negedge clk_i);
        free = !mvalid || ready_i;
        any  = 1'b0;
        sel  = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (mptr + k) % N;
            if (!any && !empty_i[c]) begin
                any = 1'b1;
                sel = c;
            end
        end
        epop = (any && free) ? (N'(1) << sel) : '0;
        check("pop", 32'(pop_o), 32'(epop));
        check("valid", 32'(valid_o), 32'(mvalid));
        if (mvalid) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                check("rsp", 32'(rsp_o), 32'(sb[0].d));
                check("src", 32'(src_o), 32'(sb[0].s));
            end
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("starve%0d", i), 32'(starve_o[i]), 32'(mwait[i] == MW));
        end
        if (mvalid && ready_i && sb.size() != 0) void'(sb.pop_front());
        if (epop != '0) begin
            e.d = head(sel);
            e.s = 2'(sel);
            sb.push_back(e);
            mptr = (sel == N - 1) ? 0 : sel + 1;
        end
        mvalid = (epop != '0) || (mvalid && !ready_i);
        for (int i = 0; i < N; i++) begin
            if (empty_i[i] || epop[i]) mwait[i] = 0;
            else if (mwait[i] < MW)    mwait[i] = mwait[i] + 1;
        end
        @(posedge clk_i);
        #1;
        if (epop[0]) void'(q0.pop_front());
        if (epop[1]) void'(q1.pop_front());
        if (epop[2]) void'(q2.pop_front());
        drive_inputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int budget;
        budget  = 60;
        ready_i = 1'b1;
        while ((qsize(0) + qsize(1) + qsize(2) != 0 || mvalid) && budget > 0) begin
            step();
            budget--;
        end
        check("drain_in_time", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        rst_ni  = 1'b0;
        ready_i = 1'b0;
        model_reset();
        drive_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid",  32'(valid_o),  32'd0);
        check("rst_rsp",    32'(rsp_o),    32'd0);
        check("rst_src",    32'(src_o),    32'd0);
        check("rst_pop",    32'(pop_o),    32'd0);
        check("rst_starve", 32'(starve_o), 32'd0);
        rst_ni = 1'b1;

        // Single input, three elements, back-to-back.
        for (int i = 0; i < 3; i++) push_in(0);
        ready_i = 1'b1;
        drive_inputs();
        steps(5);

        // Two inputs continuously non-empty: alternate with no bubble.
        for (int i = 0; i < 6; i++) begin
            push_in(0);
            push_in(1);
        end
        drive_inputs();
        steps(14);

        // Backpressure: hold X for 5 cycles, then pop in the cycle ready rises.
        push_in(0);
        push_in(0);
        ready_i = 1'b0;
        drive_inputs();
        steps(6);
        ready_i = 1'b1;
        steps(4);

        // Starvation of input 1 behind a stalled output.
        push_in(0);
        ready_i = 1'b0;
        drive_inputs();
        step();
        push_in(1);
        push_in(1);
        drive_inputs();
        steps(7);
        ready_i = 1'b1;
        steps(5);

        // Wrap: move the pointer to 2, then offer inputs 0 and 2 together.
        push_in(1);
        drive_inputs();
        steps(3);
        push_in(0);
        push_in(2);
        drive_inputs();
        steps(4);

        // Random traffic and backpressure on all three inputs.
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0 && qsize(i) < 4) push_in(i);
            end
            ready_i = ($urandom_range(0, 3) != 0);
            drive_inputs();
            step();
        end
        drain();

        // Asynchronous reset with a held response and a starving input.
        push_in(0);
        push_in(1);
        push_in(1);
        ready_i = 1'b0;
        drive_inputs();
        steps(7);
        rst_ni = 1'b0;
        #1;
        check("arst_valid",  32'(valid_o),  32'd0);
        check("arst_pop",    32'(pop_o),    32'd0);
        check("arst_starve", 32'(starve_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        push_in(0);
        drive_inputs();
        drain();
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
